led_ctrl: RTL and testbench
===========================

LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of independent LED channels (1..256).
REQ-002 SHALL have parameter CNT_W, default 16, giving the blink period counter width (1..16).
REQ-003 SHALL have parameter PWM_W, default 8, giving the PWM duty width (1..14).
REQ-004 SHALL have port i_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit, the reset; it is synchronous and active-low.
REQ-006 SHALL have port i_we, input, 1 bit, the register write strobe.
REQ-007 SHALL have port i_re, input, 1 bit, the register read strobe.
REQ-008 SHALL have port i_addr, input, 8 bits, the word index of the channel register.
REQ-009 SHALL have port i_wdata, input, 32 bits, the write data.
REQ-010 SHALL have port o_rdata, output, 32 bits, the read data.
REQ-011 SHALL have port o_rvalid, output, 1 bit, which qualifies o_rdata.
REQ-012 SHALL have port o_leds, output, NUM_CH bits, the registered LED drive, one bit per channel.

Function
REQ-013 SHALL map each channel register as follows: mode at [1:0] (00 OFF, 01 ON, 10 BLINK, 11 PWM), duty at [PWM_W+1:2], period at [15+CNT_W:16]; all other bits SHALL read 0.
REQ-014 SHALL, when i_we=1 and i_addr<NUM_CH, update the register at the next edge; when i_addr>=NUM_CH, the write SHALL be ignored.
REQ-015 SHALL, for a read with i_re=1, assert o_rvalid for exactly one cycle, 1 cycle later, with o_rdata set to the register value (0 when out of range); otherwise o_rvalid=0 and o_rdata=0.
REQ-016 SHALL, for a read and a write to the same address in the same cycle, return the pre-write value.
REQ-017 SHALL drive o_leds[ch]=0 in OFF mode and 1 in ON mode, effective 1 cycle after the write edge.
REQ-018 SHALL, in BLINK mode, increment the per-channel counter each cycle; when the counter equals period, the LED SHALL toggle and the counter SHALL clear, giving period+1 cycles per half-phase. Period 0 SHALL toggle every cycle.
REQ-019 SHALL, on any write to a channel, clear that channel's blink counter and set its blink phase to 0 (LED off), regardless of the new mode.
REQ-020 SHALL, in PWM mode, use one shared free-running PWM_W-bit counter that wraps from 2^PWM_W-1 to 0, and drive LED = (pwm_cnt < duty).
REQ-021 SHALL, in PWM mode, hold the LED constantly off for duty 0, and on for 2^PWM_W-1 of every 2^PWM_W cycles at maximum duty.

Reset
REQ-022 SHALL, while i_rst_n=0 at an edge, clear all registers, blink counters, blink phases, the PWM counter, o_leds, o_rdata and o_rvalid to 0.
REQ-023 SHALL, when reset is asserted mid-blink or mid-read, clear everything at that edge; a read accepted in the reset cycle SHALL produce no o_rvalid.

Configuration
REQ-024 SHALL, with LED_CTRL_PWM_EN defined, implement PWM mode as in REQ-020..021.
REQ-025 SHALL, without LED_CTRL_PWM_EN, omit the PWM counter; mode 11 SHALL drive the LED 0, and the duty field SHALL be neither stored nor read back (reads 0).

Structure
REQ-026 SHALL keep the mode enum, the field offsets/widths and the register count limit in package led_ctrl_pkg.
REQ-027 SHALL implement each channel (register, blink counter, output mux) in sub-module led_chan, instantiated NUM_CH times via generate; the register decode and PWM counter SHALL remain in led_ctrl.

Verification
REQ-028 SHALL verify reset: hold i_rst_n=0 for 3 cycles -> o_leds=0, o_rvalid=0; read of addr 0 -> 0x00000000.
REQ-029 SHALL verify static modes: write 0x1 to addr 2 -> o_leds[2]=1 the next cycle; write 0x0 -> o_leds[2]=0 the next cycle.
REQ-030 SHALL verify blink: write period=3, mode=10 (0x00030002) to addr 0 -> o_leds[0] toggles every 4 cycles; a rewrite mid-phase -> LED 0 and phase restart.
REQ-031 SHALL verify PWM: with PWM_W=8, write duty=64, mode=11 to addr 1 -> 64 high cycles per 256; duty 0 -> always 0.
REQ-032 SHALL verify read/write corners: same-cycle read and write to addr 3 -> old value returned; write to addr 200 -> ignored and reads 0; o_rvalid is a single-cycle pulse.
REQ-033 SHALL verify the build without LED_CTRL_PWM_EN: mode 11 -> LED 0; readback of a write of 0x00000103 -> 0x00000003.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller: channel modes, register field layout
// and the channel-count limit that sets the address width.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PWM   = 2'b11
   } mode_e;

   localparam int MODE_LSB   = 0;
   localparam int MODE_W     = 2;
   localparam int DUTY_LSB   = 2;
   localparam int PERIOD_LSB = 16;

   localparam int MAX_CH     = 256;
   localparam int ADDR_W     = $clog2(MAX_CH);

endpackage

// File: rtl/led_chan.sv
// One LED channel: control register, blink timer and registered output mux.
// Define LED_CTRL_PWM_EN to store the duty field and enable the PWM comparison.
module led_chan
   import led_ctrl_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int PWM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [1:0]       wr_mode,
   input  logic [CNT_W-1:0] wr_period,
`ifdef LED_CTRL_PWM_EN
   input  logic [PWM_W-1:0] wr_duty,
   input  logic [PWM_W-1:0] pwm_cnt,
`endif
   output logic [31:0]      reg_word,
   output logic             led
);

   mode_e            mode_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] cnt_q;
   logic             phase_q;
   logic             led_d;
`ifdef LED_CTRL_PWM_EN
   logic [PWM_W-1:0] duty_q;
`endif

   // Any write restarts the blink sequence from the off phase, whatever the new mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q   <= MODE_OFF;
         period_q <= '0;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
      end else if (we) begin
         mode_q   <= mode_e'(wr_mode);
         period_q <= wr_period;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
      end else if (mode_q == MODE_BLINK) begin
         if (cnt_q == period_q) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q   <= cnt_q + 1'b1;
         end
      end
   end

`ifdef LED_CTRL_PWM_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_q <= '0;
      end else if (we) begin
         duty_q <= wr_duty;
      end
   end
`endif

   always_comb begin
      led_d = 1'b0;
      case (mode_q)
         MODE_ON:    led_d = 1'b1;
         MODE_BLINK: led_d = phase_q;
`ifdef LED_CTRL_PWM_EN
         MODE_PWM:   led_d = (pwm_cnt < duty_q);
`endif
         default:    led_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led <= 1'b0;
      end else begin
         led <= led_d;
      end
   end

   always_comb begin
      reg_word                          = '0;
      reg_word[MODE_LSB +: MODE_W]      = mode_q;
      reg_word[PERIOD_LSB +: CNT_W]     = period_q;
`ifdef LED_CTRL_PWM_EN
      reg_word[DUTY_LSB +: PWM_W]       = duty_q;
`else
      reg_word[DUTY_LSB +: PWM_W]       = '0;
`endif
   end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller: register decode, read port and shared PWM counter.
// Define LED_CTRL_PWM_EN to build the PWM counter and mode 11 support.
module led_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int PWM_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata,
   output logic              o_rvalid,
   output logic [NUM_CH-1:0] o_leds
);

   logic [31:0] reg_word [NUM_CH];
   logic [31:0] rd_word;
   logic [31:0] rdata_p1;
   logic        vld_p1;
   logic        unused_wdata;

   // Fields outside the channel layout are simply dropped.
   assign unused_wdata = ^i_wdata;

`ifdef LED_CTRL_PWM_EN
   logic [PWM_W-1:0] pwm_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      led_chan #(
         .CNT_W (CNT_W),
         .PWM_W (PWM_W)
      ) u_chan (
         .clk       (i_clk),
         .rst_n     (i_rst_n),
         .we        (i_we && (i_addr == ADDR_W'(g))),
         .wr_mode   (i_wdata[MODE_LSB +: MODE_W]),
         .wr_period (i_wdata[PERIOD_LSB +: CNT_W]),
`ifdef LED_CTRL_PWM_EN
         .wr_duty   (i_wdata[DUTY_LSB +: PWM_W]),
         .pwm_cnt   (pwm_cnt),
`endif
         .reg_word  (reg_word[g]),
         .led       (o_leds[g])
      );
   end

   // Out-of-range addresses match no channel and read back as zero.
   always_comb begin
      rd_word = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (i_addr == ADDR_W'(c)) begin
            rd_word = reg_word[c];
         end
      end
   end

   // Read stage p1: sampled before any same-cycle write lands.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vld_p1   <= 1'b0;
         rdata_p1 <= '0;
      end else begin
         vld_p1   <= i_re;
         rdata_p1 <= i_re ? rd_word : '0;
      end
   end

   assign o_rdata  = rdata_p1;
   assign o_rvalid = vld_p1;

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: directed and randomized register traffic scored against an
// arithmetic model of the LED outputs; works with or without LED_CTRL_PWM_EN.
module tb_led_ctrl;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;
   localparam int PWM_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              we;
   logic              re;
   logic [7:0]        addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              rvalid;
   logic [NUM_CH-1:0] leds;

   led_ctrl #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .PWM_W  (PWM_W)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_we     (we),
      .i_re     (re),
      .i_addr   (addr),
      .i_wdata  (wdata),
      .o_rdata  (rdata),
      .o_rvalid (rvalid),
      .o_leds   (leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NUM_CH-1:0] leds;
      logic              rvalid;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] rd_q  [$];

   int n_cmp;
   int n_bad;

   // Model: register contents plus the edge index of each write and of the last reset.
   int m_mode    [NUM_CH];
   int m_duty    [NUM_CH];
   int m_period  [NUM_CH];
   int m_wr_edge [NUM_CH];
   int edge_n;
   int rst_edge;

   function automatic bit model_led(int c, int j);
      case (m_mode[c])
         1: return 1'b1;
         2: return (((j - m_wr_edge[c]) / (m_period[c] + 1)) % 2) == 1;
`ifdef LED_CTRL_PWM_EN
         3: return ((j - rst_edge) % (1 << PWM_W)) < m_duty[c];
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_word(int a);
      logic [31:0] w;
      if (a >= NUM_CH) return 32'h0;
      w = 32'(m_mode[a]) | (32'(m_period[a]) << 16);
`ifdef LED_CTRL_PWM_EN
      w = w | (32'(m_duty[a]) << 2);
`endif
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // One clock of stimulus; expectations for the coming edge are queued first.
   task automatic step(input bit r, input bit w, input bit rd, input int a, input logic [31:0] d);
      exp_t e;
      @(negedge clk);
      rst_n = r;
      we    = w;
      re    = rd;
      addr  = 8'(a);
      wdata = d;
      e.rvalid = r && rd;
      for (int c = 0; c < NUM_CH; c++) e.leds[c] = r ? model_led(c, edge_n) : 1'b0;
      exp_q.push_back(e);
      if (r && rd) rd_q.push_back(model_word(a));
      edge_n++;
      if (!r) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c]   = 0;
            m_duty[c]   = 0;
            m_period[c] = 0;
         end
         rst_edge = edge_n;
      end else if (w && a < NUM_CH) begin
         m_mode[a]    = int'(d[1:0]);
         m_duty[a]    = int'(d[15:2]) % (1 << PWM_W);
         m_period[a]  = int'(d[31:16]) % (1 << CNT_W);
         m_wr_edge[a] = edge_n;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 32'h0);
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      step(1'b1, 1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input int a);
      step(1'b1, 1'b0, 1'b1, a, 32'h0);
   endtask

   // Monitor: one expectation per edge, read data popped whenever o_rvalid is seen.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("leds", 32'(leds), 32'(e.leds));
            check("rvalid", 32'(rvalid), 32'(e.rvalid));
            if (rvalid === 1'b1) begin
               if (rd_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL rvalid_extra: actual 1 required 0 at %0t", $time);
               end else begin
                  check("rdata", rdata, rd_q.pop_front());
               end
            end else begin
               check("rdata_idle", rdata, 32'h0);
            end
         end
      end
   end

   initial begin
      bit          r;
      bit          w;
      bit          rdv;
      int          a;
      logic [31:0] d;

      rst_n = 1'b0;
      we    = 1'b0;
      re    = 1'b0;
      addr  = '0;
      wdata = '0;

      // Reset, including a read issued during reset.
      step(1'b0, 1'b0, 1'b0, 0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 0, 32'h0);
      rd(0);
      idle(2);

      // Static on/off.
      wr(2, 32'h0000_0001);
      idle(1);
      wr(2, 32'h0000_0000);
      idle(2);

      // Blink with period 3, then a rewrite in the middle of the on phase.
      wr(0, 32'h0003_0002);
      idle(13);
      wr(0, 32'h0003_0002);
      idle(10);
      rd(0);
      idle(1);

      // Mode 11: duty 64, duty 0, maximum duty.
      wr(1, 32'h0000_0103);
      idle(300);
      rd(1);
      idle(1);
      wr(1, 32'h0000_0003);
      idle(40);
      wr(1, 32'h0000_03FF);
      idle(260);
      rd(1);

      // Same-cycle read and write, out-of-range access.
      wr(3, 32'h0001_0001);
      step(1'b1, 1'b1, 1'b1, 3, 32'h0000_0000);
      rd(3);
      idle(1);
      wr(200, 32'hFFFF_FFFF);
      rd(200);
      for (int i = 0; i < NUM_CH; i++) rd(i);
      idle(2);

      // Reset mid-blink right after a read, with a read in the reset cycle.
      wr(0, 32'h0001_0002);
      idle(5);
      rd(0);
      step(1'b0, 1'b0, 1'b1, 0, 32'h0);
      idle(2);
      rd(0);
      idle(2);

      // Random traffic.
      for (int i = 0; i < 2500; i++) begin
         r   = ($urandom_range(0, 299) != 0);
         w   = ($urandom_range(0, 5) == 0);
         rdv = ($urandom_range(0, 2) == 0);
         a   = ($urandom_range(0, 15) == 0) ? 200 : int'($urandom_range(0, NUM_CH + 1));
         d   = ($urandom_range(0, 6) << 16) | ($urandom & 32'h0000_FFFF);
         step(r, w, rdv, a, d);
      end
      idle(3);

      @(posedge clk);
      #3;
      check("rd_queue_drained", 32'(rd_q.size()), 32'h0);
      check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
